regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Parametrised successor of the processor register file: configurable data width, register count and number of combinational read ports.
- Register 0 is hardwired to zero.
- Adds a per-register busy scoreboard for multi-cycle ops (mult/div) and a sequential bulk-clear engine.
- Sits between decode/writeback in the pipeline; stall logic consumes the busy flags.

Parameters:
- DATA_WIDTH, 32, bits per register
- ADDR_WIDTH, 5, register address width; DEPTH = 2**ADDR_WIDTH registers
- NUM_READ, 2, number of independent read ports (>=1)

Ports:
- clock  input  1  single clock, all state updates on rising edge
- ctrl_reset  input  1  reset; one clock; reset is synchronous and active-low
- ctrl_writeEnable  input  1  write request this cycle
- ctrl_writeReg  input  ADDR_WIDTH  write address
- data_writeReg  input  DATA_WIDTH  write data
- ctrl_readReg  input  NUM_READ*ADDR_WIDTH  read addresses; port k at bits [k*ADDR_WIDTH +: ADDR_WIDTH]
- data_readReg  output  NUM_READ*DATA_WIDTH  read data; port k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- read_busy  output  NUM_READ  busy bit of the register addressed by port k
- ctrl_reserveEnable  input  1  mark a register busy (multi-cycle op issued)
- ctrl_reserveReg  input  ADDR_WIDTH  register to reserve
- ctrl_clear  input  1  start bulk clear (level sampled in IDLE)
- clear_busy  output  1  high while the clear engine runs
- clear_done  output  1  one-cycle pulse when the clear completes
- write_dropped  output  1  registered pulse: a write or reserve was ignored in the previous cycle

Behaviour:
- Reset (ctrl_reset==0 at edge):
  - all registers 0, all busy bits 0
  - FSM to IDLE; clear_busy=0, clear_done=0, write_dropped=0
  - reset has priority over every other input, including an in-progress clear
- Reads:
  - combinational, zero latency; data_readReg[k] = reg[addr_k]
  - address 0 always reads 0 with read_busy 0
- Write:
  - in IDLE with ctrl_writeEnable=1 and addr!=0, reg[addr] <= data_writeReg at the edge and busy[addr] <= 0
  - written value is visible on read ports the cycle after the edge
  - writes to address 0 are silently ignored and do not set write_dropped
- Reserve:
  - in IDLE with ctrl_reserveEnable=1 and addr!=0, busy[addr] <= 1
  - reserve of address 0 is ignored
  - write and reserve to the same register in the same cycle: data is written and busy ends at 1 (reserve wins)
  - write and reserve to different registers both take effect
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR when ctrl_clear=1. The clear pointer is loaded with 1, clear_busy goes high the next cycle, and any write or reserve in the same cycle is still honoured.
  - In CLEAR, each cycle reg[ptr] <= 0, busy[ptr] <= 0, ptr <= ptr+1. DEPTH-1 cycles in total.
  - CLEAR -> IDLE at the cycle ptr==DEPTH-1 is cleared; clear_done pulses high for exactly one cycle coincident with the first IDLE cycle; clear_busy drops the same cycle.
  - ctrl_clear during CLEAR is ignored (no restart). ctrl_clear held high in IDLE after completion starts a new clear.
- During CLEAR:
  - ctrl_writeEnable or ctrl_reserveEnable (addr!=0) are ignored and write_dropped=1 the following cycle
  - reads return current contents: already-cleared entries read 0, pending entries read the old value
- Pointer width is ADDR_WIDTH; it never wraps past DEPTH-1.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined:
  - read port k returns data_writeReg combinationally when an IDLE write is active, ctrl_writeReg==addr_k and addr_k!=0
  - read_busy[k] reports 0 in that case, unless a same-cycle reserve targets the same register, in which case it reports 1
  - no bypass during CLEAR
- Undefined: reads show the old value until the cycle after the write edge.

Test Plan:
- Reset then write 0xDEADBEEF to r5, read r5 on port 0 and r0 on port 1 next cycle -> 0xDEADBEEF and 0x00000000; read_busy = 2'b00.
- Write 0x12345678 to r0, then read r0 -> 0; write_dropped stays 0.
- Reserve r7 -> read_busy=1 for r7. Then write and reserve r7 together with 0xA5A5A5A5 -> data 0xA5A5A5A5, busy still 1. Plain write r7 -> busy 0.
- Fill r1..r31 with index values and pulse ctrl_clear.
  - clear_busy is high for 31 cycles.
  - Mid-clear (cycle 10), r3 reads 0 and r20 reads 20.
  - A write to r20 in cycle 10 is dropped and write_dropped pulses.
  - clear_done is a single pulse, after which all registers read 0.
- Assert ctrl_reset low at cycle 5 of a clear -> next cycle IDLE, clear_busy=0, no clear_done, all registers and busy bits 0.
- With REGFILE_BYPASS_EN: write 0xCAFEF00D to r9 while port 1 reads r9 in the same cycle -> port 1 shows 0xCAFEF00D that cycle. Without the macro it shows the previous value.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: parametrised register file with a per-register busy
// scoreboard and a sequential bulk-clear engine.
// Register 0 is hardwired to zero and is never marked busy.
// Optional feature: define REGFILE_BYPASS_EN to forward an IDLE-state write
// combinationally to any read port addressing the same register.
module regfile_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2
) (
    input  logic                           clock,
    input  logic                           ctrl_reset,
    input  logic                           ctrl_writeEnable,
    input  logic [ADDR_WIDTH-1:0]          ctrl_writeReg,
    input  logic [DATA_WIDTH-1:0]          data_writeReg,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] ctrl_readReg,
    output logic [NUM_READ*DATA_WIDTH-1:0] data_readReg,
    output logic [NUM_READ-1:0]            read_busy,
    input  logic                           ctrl_reserveEnable,
    input  logic [ADDR_WIDTH-1:0]          ctrl_reserveReg,
    input  logic                           ctrl_clear,
    output logic                           clear_busy,
    output logic                           clear_done,
    output logic                           write_dropped
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_REG = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] FIRST_REG = ADDR_WIDTH'(1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic [DATA_WIDTH-1:0]   regs [DEPTH];
    logic [DEPTH-1:0]        busy;
    logic [ADDR_WIDTH-1:0]   clear_ptr;
    logic                    done_q;
    logic                    dropped_q;
    logic                    write_valid;
    logic                    reserve_valid;

    // Requests to register 0 are treated as if they never happened.
    assign write_valid   = ctrl_writeEnable && (ctrl_writeReg != '0);
    assign reserve_valid = ctrl_reserveEnable && (ctrl_reserveReg != '0);

    // State register plus the registered completion and dropped-request pulses.
    always_ff @(posedge clock) begin
        if (!ctrl_reset) begin
            state     <= IDLE;
            done_q    <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            state     <= next_state;
            done_q    <= (state == CLEAR) && (next_state == IDLE);
            dropped_q <= (state == CLEAR) && (write_valid || reserve_valid);
        end
    end

    // Next-state: start a clear from IDLE, leave CLEAR once the last entry is wiped.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (ctrl_clear) next_state = CLEAR;
            CLEAR:   if (clear_ptr == LAST_REG) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Status outputs derived from the FSM state and its registered pulses.
    always_comb begin
        clear_busy    = (state == CLEAR);
        clear_done    = done_q;
        write_dropped = dropped_q;
    end

    // Clear pointer walks 1..DEPTH-1 and parks at the last entry instead of wrapping.
    always_ff @(posedge clock) begin
        if (!ctrl_reset) begin
            clear_ptr <= '0;
        end else if (state == IDLE) begin
            if (ctrl_clear) begin
                clear_ptr <= FIRST_REG;
            end
        end else if (clear_ptr != LAST_REG) begin
            clear_ptr <= clear_ptr + FIRST_REG;
        end
    end

    // Storage and scoreboard: reserve is applied after write so it wins on a collision.
    always_ff @(posedge clock) begin
        if (!ctrl_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else if (state == IDLE) begin
            if (write_valid) begin
                regs[ctrl_writeReg] <= data_writeReg;
                busy[ctrl_writeReg] <= 1'b0;
            end
            if (reserve_valid) begin
                busy[ctrl_reserveReg] <= 1'b1;
            end
        end else begin
            regs[clear_ptr] <= '0;
            busy[clear_ptr] <= 1'b0;
        end
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : g_read
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] rdata;
        logic                  rbusy;

        assign addr = ctrl_readReg[k*ADDR_WIDTH +: ADDR_WIDTH];

        // Combinational read port; register 0 always reads zero and not busy.
        always_comb begin
            rdata = regs[addr];
            rbusy = busy[addr];
`ifdef REGFILE_BYPASS_EN
            if ((state == IDLE) && write_valid && (ctrl_writeReg == addr)) begin
                rdata = data_writeReg;
                rbusy = reserve_valid && (ctrl_reserveReg == addr);
            end
`endif
            if (addr == '0) begin
                rdata = '0;
                rbusy = 1'b0;
            end
        end

        assign data_readReg[k*DATA_WIDTH +: DATA_WIDTH] = rdata;
        assign read_busy[k] = rbusy;
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Testbench for regfile_scoreboard: directed scenarios followed by random
// traffic, all checked against a behavioural model of the register file.
module tb_regfile_scoreboard;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int DEPTH = 32;

    logic           clock = 1'b0;
    logic           ctrl_reset = 1'b0;
    logic           ctrl_writeEnable = 1'b0;
    logic [AW-1:0]  ctrl_writeReg = '0;
    logic [DW-1:0]  data_writeReg = '0;
    logic [NR*AW-1:0] ctrl_readReg = '0;
    logic [NR*DW-1:0] data_readReg;
    logic [NR-1:0]  read_busy;
    logic           ctrl_reserveEnable = 1'b0;
    logic [AW-1:0]  ctrl_reserveReg = '0;
    logic           ctrl_clear = 1'b0;
    logic           clear_busy;
    logic           clear_done;
    logic           write_dropped;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: contents, busy flags, and clear progress as a count of entries left.
    logic [DW-1:0] m_regs [DEPTH];
    bit            m_busy [DEPTH];
    int            m_clear_left = 0;
    bit            m_done = 0;
    bit            m_dropped = 0;

    regfile_scoreboard #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR)) dut (
        .clock              (clock),
        .ctrl_reset         (ctrl_reset),
        .ctrl_writeEnable   (ctrl_writeEnable),
        .ctrl_writeReg      (ctrl_writeReg),
        .data_writeReg      (data_writeReg),
        .ctrl_readReg       (ctrl_readReg),
        .data_readReg       (data_readReg),
        .read_busy          (read_busy),
        .ctrl_reserveEnable (ctrl_reserveEnable),
        .ctrl_reserveReg    (ctrl_reserveReg),
        .ctrl_clear         (ctrl_clear),
        .clear_busy         (clear_busy),
        .clear_done         (clear_done),
        .write_dropped      (write_dropped)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [DW-1:0] expRead(input logic [AW-1:0] a);
        if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (m_clear_left == 0 && ctrl_writeEnable && ctrl_writeReg == a) return data_writeReg;
`endif
        return m_regs[a];
    endfunction

    function automatic logic expBusy(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (m_clear_left == 0 && ctrl_writeEnable && ctrl_writeReg == a)
            return ctrl_reserveEnable && (ctrl_reserveReg == a);
`endif
        return m_busy[a];
    endfunction

    task automatic checkAll();
        for (int k = 0; k < NR; k++) begin
            logic [AW-1:0] a;
            a = ctrl_readReg[k*AW +: AW];
            checkOutput($sformatf("data_p%0d_r%0d", k, a), 64'(data_readReg[k*DW +: DW]), 64'(expRead(a)));
            checkOutput($sformatf("busy_p%0d_r%0d", k, a), 64'(read_busy[k]), 64'(expBusy(a)));
        end
        checkOutput("clear_busy", 64'(clear_busy), 64'(m_clear_left > 0));
        checkOutput("clear_done", 64'(clear_done), 64'(m_done));
        checkOutput("write_dropped", 64'(write_dropped), 64'(m_dropped));
    endtask

    task automatic modelEdge();
        bit wv;
        bit rv;
        int idx;
        if (!ctrl_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_regs[i] = '0;
                m_busy[i] = 0;
            end
            m_clear_left = 0;
            m_done = 0;
            m_dropped = 0;
        end else begin
            wv = ctrl_writeEnable && (ctrl_writeReg != 0);
            rv = ctrl_reserveEnable && (ctrl_reserveReg != 0);
            m_dropped = (m_clear_left > 0) && (wv || rv);
            if (m_clear_left > 0) begin
                idx = DEPTH - m_clear_left;
                m_regs[idx] = '0;
                m_busy[idx] = 0;
                m_clear_left--;
                m_done = (m_clear_left == 0);
            end else begin
                m_done = 0;
                if (wv) begin
                    m_regs[ctrl_writeReg] = data_writeReg;
                    m_busy[ctrl_writeReg] = 0;
                end
                if (rv) m_busy[ctrl_reserveReg] = 1;
                if (ctrl_clear) m_clear_left = DEPTH - 1;
            end
        end
    endtask

    task automatic stepCycle();
        @(negedge clock);
        checkAll();
        @(posedge clock);
        modelEdge();
        #1;
    endtask

    task automatic applyStimulus(input bit rst_n, input bit we, input logic [AW-1:0] wa,
                                 input logic [DW-1:0] wd, input bit re, input logic [AW-1:0] ra,
                                 input bit clr, input logic [AW-1:0] p0, input logic [AW-1:0] p1);
        ctrl_reset         = rst_n;
        ctrl_writeEnable   = we;
        ctrl_writeReg      = wa;
        data_writeReg      = wd;
        ctrl_reserveEnable = re;
        ctrl_reserveReg    = ra;
        ctrl_clear         = clr;
        ctrl_readReg       = {p1, p0};
        stepCycle();
    endtask

    task automatic idleRead(input logic [AW-1:0] p0, input logic [AW-1:0] p1);
        applyStimulus(1, 0, '0, '0, 0, '0, 0, p0, p1);
    endtask

    initial begin
        int n;
        // Bring-up: one unchecked reset edge so model and DUT start from a known state.
        @(posedge clock);
        modelEdge();
        #1;
        applyStimulus(0, 0, '0, '0, 0, '0, 0, 5'd0, 5'd0);
        idleRead(5'd5, 5'd0);
        checkOutput("reset_clear_busy", 64'(clear_busy), 64'd0);
        checkOutput("reset_r5", 64'(data_readReg[DW-1:0]), 64'd0);

        // Write r5 and read it back next cycle alongside r0.
        applyStimulus(1, 1, 5'd5, 32'hDEADBEEF, 0, '0, 0, 5'd5, 5'd0);
        idleRead(5'd5, 5'd0);
        checkOutput("r5_value", 64'(data_readReg[DW-1:0]), 64'hDEADBEEF);
        checkOutput("r0_value", 64'(data_readReg[2*DW-1:DW]), 64'd0);
        checkOutput("r5_r0_busy", 64'(read_busy), 64'd0);

        // Writes to r0 are silently ignored.
        applyStimulus(1, 1, 5'd0, 32'h12345678, 0, '0, 0, 5'd0, 5'd0);
        idleRead(5'd0, 5'd0);
        checkOutput("r0_after_write", 64'(data_readReg[DW-1:0]), 64'd0);
        checkOutput("r0_no_drop", 64'(write_dropped), 64'd0);

        // Reserve r7, then write+reserve (reserve wins), then plain write frees it.
        applyStimulus(1, 0, '0, '0, 1, 5'd7, 0, 5'd7, 5'd0);
        idleRead(5'd7, 5'd0);
        checkOutput("r7_reserved", 64'(read_busy[0]), 64'd1);
        applyStimulus(1, 1, 5'd7, 32'hA5A5A5A5, 1, 5'd7, 0, 5'd7, 5'd0);
        idleRead(5'd7, 5'd0);
        checkOutput("r7_wr_rsv_data", 64'(data_readReg[DW-1:0]), 64'hA5A5A5A5);
        checkOutput("r7_wr_rsv_busy", 64'(read_busy[0]), 64'd1);
        applyStimulus(1, 1, 5'd7, 32'h00000007, 0, '0, 0, 5'd7, 5'd0);
        idleRead(5'd7, 5'd0);
        checkOutput("r7_freed", 64'(read_busy[0]), 64'd0);

        // Fill r1..r31 with their index, then run a full clear.
        for (int i = 1; i < DEPTH; i++) applyStimulus(1, 1, AW'(i), DW'(i), 0, '0, 0, AW'(i), 5'd0);
        applyStimulus(1, 0, '0, '0, 0, '0, 1, 5'd3, 5'd20);
        n = 0;
        while (clear_busy && n < 40) begin
            n++;
            if (n == 10) begin
                checkOutput("mid_clear_r3", 64'(data_readReg[DW-1:0]), 64'd0);
                checkOutput("mid_clear_r20", 64'(data_readReg[2*DW-1:DW]), 64'd20);
                applyStimulus(1, 1, 5'd20, 32'hFFFF0000, 0, '0, 0, 5'd3, 5'd20);
                checkOutput("mid_clear_dropped", 64'(write_dropped), 64'd1);
            end else begin
                idleRead(5'd3, 5'd20);
            end
        end
        checkOutput("clear_length", 64'(n), 64'd31);
        checkOutput("clear_done_pulse", 64'(clear_done), 64'd1);
        idleRead(5'd20, 5'd31);
        checkOutput("clear_done_single", 64'(clear_done), 64'd0);
        for (int i = 0; i < DEPTH; i += 2) idleRead(AW'(i), AW'(i + 1));

        // Reset during a clear aborts it without a completion pulse.
        applyStimulus(1, 1, 5'd12, 32'h0BADF00D, 1, 5'd13, 0, 5'd12, 5'd13);
        applyStimulus(1, 0, '0, '0, 0, '0, 1, 5'd12, 5'd13);
        for (int i = 0; i < 4; i++) idleRead(5'd12, 5'd13);
        applyStimulus(0, 0, '0, '0, 0, '0, 0, 5'd12, 5'd13);
        idleRead(5'd12, 5'd13);
        checkOutput("abort_clear_busy", 64'(clear_busy), 64'd0);
        checkOutput("abort_r12", 64'(data_readReg[DW-1:0]), 64'd0);
        checkOutput("abort_r13_busy", 64'(read_busy[1]), 64'd0);
        for (int i = 0; i < DEPTH; i += 2) idleRead(AW'(i), AW'(i + 1));

        // Same-cycle write/read of r9 exercises the bypass path (or its absence).
        applyStimulus(1, 1, 5'd9, 32'h11111111, 0, '0, 0, 5'd0, 5'd9);
        ctrl_writeEnable = 1;
        ctrl_writeReg    = 5'd9;
        data_writeReg    = 32'hCAFEF00D;
        ctrl_readReg     = {5'd9, 5'd0};
        #1;
`ifdef REGFILE_BYPASS_EN
        checkOutput("bypass_r9", 64'(data_readReg[2*DW-1:DW]), 64'hCAFEF00D);
`else
        checkOutput("no_bypass_r9", 64'(data_readReg[2*DW-1:DW]), 64'h11111111);
`endif
        stepCycle();

        // Random traffic with occasional clears and resets.
        for (int c = 0; c < 800; c++) begin
            logic [AW-1:0] wa;
            wa = AW'($urandom_range(0, DEPTH - 1));
            applyStimulus($urandom_range(0, 99) != 0, $urandom_range(0, 1) == 1, wa, DW'($urandom),
                          $urandom_range(0, 2) == 0, AW'($urandom_range(0, DEPTH - 1)),
                          $urandom_range(0, 39) == 0,
                          ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, DEPTH - 1)),
                          AW'($urandom_range(0, DEPTH - 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
